// File: rtl/ddf_1p_2f_route_pkg.sv
// rtl/ddf_1p_2f_route_pkg.sv - shared DDF state encodings and tag-bit helper
package ddf_1p_2f_route_pkg;

  // Shared with the pick actor: keep these encodings stable.
  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_ANN  = 2'd1,
    ST_XFER = 2'd2
  } ddf_st_e;

  // Flow tag sits in the MSB of a header/NDA token.
  function automatic int ddf_tag_bit(input int width_nda);
    return width_nda - 1;
  endfunction

endpackage

// File: rtl/ddf_burst_cnt.sv
// rtl/ddf_burst_cnt.sv - loadable burst down-counter with last-word flag
module ddf_burst_cnt #(
  parameter int W = 7
) (
  input  logic         ck_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         last_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load wins over decrement; the caller never asks for both at once.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge ck_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == W'(1));

endmodule

// File: rtl/ddf_1p_2f_route.sv
// rtl/ddf_1p_2f_route.sv - 2-flow DDF dispatch router; DDF_ROUTE_TAG_CHECK_EN enables tag checking
module ddf_1p_2f_route
  import ddf_1p_2f_route_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int WIDTH_NDA = 8
) (
  input  logic                 ck,
  input  logic                 rst,
  input  logic [WIDTH_NDA-1:0] nda_data,
  input  logic                 nda_empty,
  output logic                 nda_read,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_empty,
  output logic                 in_read,
  output logic [WIDTH_NDA-1:0] nda0_out,
  output logic                 nda0_wr,
  input  logic                 nda0_full,
  output logic [WIDTH_NDA-1:0] nda1_out,
  output logic                 nda1_wr,
  input  logic                 nda1_full,
  output logic [WIDTH-1:0]     out0_data,
  output logic                 out0_wr,
  input  logic                 out0_full,
  output logic [WIDTH-1:0]     out1_data,
  output logic                 out1_wr,
  input  logic                 out1_full,
  output logic                 err
);

  localparam int CW      = WIDTH_NDA - 1;
  localparam int TAG_BIT = ddf_tag_bit(WIDTH_NDA);

  ddf_st_e       st_q, st_d;
  logic          dest_q, dest_d;
  logic [CW-1:0] n_q, n_d;
  logic [CW-1:0] hdr_n;
  logic          cnt_load, cnt_dec, cnt_last;
  logic          nda_read_c, nda_wr_c, in_read_c, out_wr_c;
  logic          sel_nda_full, sel_out_full;
  logic          tag_bad;

  assign hdr_n        = nda_data[CW-1:0];
  assign sel_nda_full = dest_q ? nda1_full : nda0_full;
  assign sel_out_full = dest_q ? out1_full : out0_full;

`ifdef DDF_ROUTE_TAG_CHECK_EN
  assign tag_bad = (in_data[WIDTH-1] != dest_q);
`else
  assign tag_bad = 1'b0;
`endif

  ddf_burst_cnt #(.W(CW)) u_cnt (
    .ck_i       (ck),
    .rst_i      (rst),
    .load_i     (cnt_load),
    .load_val_i (hdr_n),
    .dec_i      (cnt_dec),
    .last_o     (cnt_last)
  );

  // Next state and raw strobes; a mistagged word is popped and dropped even when the output is full.
  always_comb begin
    st_d       = st_q;
    dest_d     = dest_q;
    n_d        = n_q;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    nda_read_c = 1'b0;
    nda_wr_c   = 1'b0;
    in_read_c  = 1'b0;
    out_wr_c   = 1'b0;
    case (st_q)
      ST_HDR: begin
        if (!nda_empty) begin
          nda_read_c = 1'b1;
          dest_d     = nda_data[TAG_BIT];
          n_d        = hdr_n;
          cnt_load   = 1'b1;
          if (hdr_n != '0) st_d = ST_ANN;
        end
      end
      ST_ANN: begin
        if (!sel_nda_full) begin
          nda_wr_c = 1'b1;
          st_d     = ST_XFER;
        end
      end
      ST_XFER: begin
        if (!in_empty) begin
          if (tag_bad) begin
            in_read_c = 1'b1;
            cnt_dec   = 1'b1;
          end else if (!sel_out_full) begin
            in_read_c = 1'b1;
            out_wr_c  = 1'b1;
            cnt_dec   = 1'b1;
          end
          if (cnt_dec && cnt_last) st_d = ST_HDR;
        end
      end
      default: st_d = ST_HDR;
    endcase
  end

  // State, destination and burst-length registers.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      st_q   <= ST_HDR;
      dest_q <= 1'b0;
      n_q    <= '0;
    end else begin
      st_q   <= st_d;
      dest_q <= dest_d;
      n_q    <= n_d;
    end
  end

`ifdef DDF_ROUTE_TAG_CHECK_EN
  logic err_q;

  // Sticky mismatch flag, cleared only by reset.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (st_q == ST_XFER && !in_empty && tag_bad) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Strobes are suppressed while reset is held so no FIFO moves during reset.
  assign nda_read  = nda_read_c & ~rst;
  assign in_read   = in_read_c & ~rst;
  assign nda0_wr   = nda_wr_c & ~dest_q & ~rst;
  assign nda1_wr   = nda_wr_c & dest_q & ~rst;
  assign out0_wr   = out_wr_c & ~dest_q & ~rst;
  assign out1_wr   = out_wr_c & dest_q & ~rst;
  assign nda0_out  = {1'b0, n_q};
  assign nda1_out  = {1'b1, n_q};
  assign out0_data = in_data;
  assign out1_data = in_data;

endmodule
